// File: rtl/counter_timer_ctrl.sv
// Programmable interval timer: prescaled up-counter with one-shot/periodic
// terminal-count ticks, pause/stop control and a saturating period counter.
module counter_timer_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4,
  parameter int PERIOD_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  paused,
  output logic                  start_ack,
  output logic                  tick,
  output logic                  done,
  output logic [PERIOD_W-1:0]   periods
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t                r_state;
  logic [WIDTH-1:0]      r_count;
  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [PERIOD_W-1:0]   r_periods;
  logic                  r_busy;
  logic                  r_paused;
  logic                  r_start_ack;
  logic                  r_tick;
  logic                  r_done;
  logic [WIDTH-1:0]      r_limit;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_mode;

  logic                  w_step;
  logic                  w_terminal;
  logic [PERIOD_W-1:0]   w_periods_next;

  assign w_step         = (r_pre_cnt == r_prescale);
  assign w_terminal     = (r_count == r_limit);
  assign w_periods_next = (r_periods == {PERIOD_W{1'b1}}) ? r_periods
                                                         : r_periods + PERIOD_W'(1);

  // Control FSM and datapath; pulses default low and are set for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_pre_cnt   <= '0;
      r_periods   <= '0;
      r_busy      <= 1'b0;
      r_paused    <= 1'b0;
      r_start_ack <= 1'b0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_limit     <= '0;
      r_prescale  <= '0;
      r_mode      <= 1'b0;
    end else begin
      r_start_ack <= 1'b0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_limit     <= limit;
            r_prescale  <= prescale;
            r_mode      <= mode;
            r_count     <= '0;
            r_pre_cnt   <= '0;
            r_periods   <= '0;
            r_start_ack <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_RUN;
          end
        end
        S_RUN: begin
          // Stop outranks pause, which outranks any step (terminal or not).
          if (stop) begin
            r_count   <= '0;
            r_pre_cnt <= '0;
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
          end else if (pause) begin
            r_paused <= 1'b1;
            r_state  <= S_PAUSE;
          end else if (!w_step) begin
            r_pre_cnt <= r_pre_cnt + PRESCALE_W'(1);
          end else begin
            r_pre_cnt <= '0;
            if (!w_terminal) begin
              r_count <= r_count + WIDTH'(1);
            end else begin
              r_count   <= '0;
              r_tick    <= 1'b1;
              r_periods <= w_periods_next;
              if (!r_mode) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_PAUSE: begin
          if (stop) begin
            r_count   <= '0;
            r_pre_cnt <= '0;
            r_busy    <= 1'b0;
            r_paused  <= 1'b0;
            r_state   <= S_IDLE;
          end else if (!pause) begin
            r_paused <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        default: begin
          r_count   <= '0;
          r_pre_cnt <= '0;
          r_busy    <= 1'b0;
          r_paused  <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign count     = r_count;
  assign busy      = r_busy;
  assign paused    = r_paused;
  assign start_ack = r_start_ack;
  assign tick      = r_tick;
  assign done      = r_done;
  assign periods   = r_periods;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed self-checking bench for counter_timer_ctrl (WIDTH=4, PRESCALE_W=4, PERIOD_W=8).
module tb_counter_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, pause, mode;
  logic [3:0] limit;
  logic [3:0] prescale;
  logic [3:0] count;
  logic       busy, paused, start_ack, tick, done;
  logic [7:0] periods;

  int checks   = 0;
  int failures = 0;

  counter_timer_ctrl #(.WIDTH(4), .PRESCALE_W(4), .PERIOD_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .limit(limit), .prescale(prescale), .count(count),
    .busy(busy), .paused(paused), .start_ack(start_ack), .tick(tick),
    .done(done), .periods(periods)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue an accepted start (edge E0) and drop start afterwards.
  task automatic do_start(input logic m, input logic [3:0] lim, input logic [3:0] pre);
    mode = m; limit = lim; prescale = pre; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0;
    limit = 4'd0; prescale = 4'd0;
    step();
    checks++; if (count !== 4'd0)   begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if ({busy, paused, start_ack, tick, done} !== 5'b00000) begin failures++; $display("FAIL rst_flags got=%b exp=00000", {busy, paused, start_ack, tick, done}); end
    checks++; if (periods !== 8'd0) begin failures++; $display("FAIL rst_periods got=%0d exp=0", periods); end
    reset = 1'b0;
    step();
    do_start(1'b0, 4'd7, 4'd0);
    step(); step();
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL rst_prerun_count got=%0d exp=2", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_async_count got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0 || tick !== 1'b0) begin failures++; $display("FAIL rst_async_busy_tick got=%b%b exp=00", busy, tick); end
    #1 reset = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL rst_idle_after got busy=%b count=%0d exp busy=0 count=0", busy, count); end
  endtask

  task automatic test_oneshot();
    do_start(1'b0, 4'd3, 4'd0);
    checks++; if (start_ack !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL os_ack got ack=%b busy=%b exp 1 1", start_ack, busy); end
    checks++; if (count !== 4'd0 || periods !== 8'd0) begin failures++; $display("FAIL os_e0 got count=%0d periods=%0d exp 0 0", count, periods); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (count !== 4'(i) || tick !== 1'b0 || start_ack !== 1'b0) begin failures++; $display("FAIL os_count_e%0d got count=%0d tick=%b ack=%b exp count=%0d tick=0 ack=0", i, count, tick, start_ack, i); end
    end
    step();
    checks++; if (count !== 4'd0 || tick !== 1'b1 || done !== 1'b1) begin failures++; $display("FAIL os_terminal got count=%0d tick=%b done=%b exp 0 1 1", count, tick, done); end
    checks++; if (busy !== 1'b0 || periods !== 8'd1) begin failures++; $display("FAIL os_end got busy=%b periods=%0d exp 0 1", busy, periods); end
    step();
    checks++; if (tick !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL os_after got tick=%b done=%b count=%0d exp 0 0 0", tick, done, count); end
  endtask

  task automatic test_periodic();
    logic [3:0] exp_cnt [12] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};
    int nt;
    do_start(1'b1, 4'd2, 4'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (count !== exp_cnt[i] || tick !== ((i == 5) || (i == 11))) begin failures++; $display("FAIL per_seq_e%0d got count=%0d tick=%b exp count=%0d tick=%b", i + 1, count, tick, exp_cnt[i], (i == 5) || (i == 11)); end
    end
    checks++; if (periods !== 8'd2 || busy !== 1'b1) begin failures++; $display("FAIL per_two got periods=%0d busy=%b exp 2 1", periods, busy); end
    nt = 2;
    for (int i = 0; i < 2000 && nt < 300; i++) begin
      step();
      if (tick) begin
        nt++;
        if (nt == 255) begin
          checks++; if (periods !== 8'd255) begin failures++; $display("FAIL per_at255 got=%0d exp=255", periods); end
        end
      end
    end
    checks++; if (nt !== 300) begin failures++; $display("FAIL per_tick_count got=%0d exp=300", nt); end
    checks++; if (periods !== 8'd255) begin failures++; $display("FAIL per_saturate got=%0d exp=255", periods); end
    do_stop();
    checks++; if (busy !== 1'b0 || count !== 4'd0 || periods !== 8'd255) begin failures++; $display("FAIL per_stop got busy=%b count=%0d periods=%0d exp 0 0 255", busy, count, periods); end
  endtask

  task automatic test_pause();
    do_start(1'b1, 4'd3, 4'd0);
    step();
    checks++; if (count !== 4'd1) begin failures++; $display("FAIL pau_pre got=%0d exp=1", count); end
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (count !== 4'd1 || paused !== 1'b1 || tick !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL pau_hold_%0d got count=%0d paused=%b tick=%b busy=%b exp 1 1 0 1", i, count, paused, tick, busy); end
    end
    pause = 1'b0;
    step();
    checks++; if (count !== 4'd1 || paused !== 1'b0) begin failures++; $display("FAIL pau_resume got count=%0d paused=%b exp 1 0", count, paused); end
    step();
    checks++; if (count !== 4'd2) begin failures++; $display("FAIL pau_cont2 got=%0d exp=2", count); end
    step();
    checks++; if (count !== 4'd3 || tick !== 1'b0) begin failures++; $display("FAIL pau_cont3 got count=%0d tick=%b exp 3 0", count, tick); end
    step();
    checks++; if (count !== 4'd0 || tick !== 1'b1) begin failures++; $display("FAIL pau_tick_e9 got count=%0d tick=%b exp 0 1", count, tick); end
    do_stop();
  endtask

  task automatic test_stop_terminal();
    do_start(1'b1, 4'd1, 4'd0);
    step(); step(); step();
    checks++; if (count !== 4'd1 || periods !== 8'd1) begin failures++; $display("FAIL stp_setup got count=%0d periods=%0d exp 1 1", count, periods); end
    do_stop();
    checks++; if (tick !== 1'b0 || count !== 4'd0 || busy !== 1'b0 || periods !== 8'd1) begin failures++; $display("FAIL stp_periodic got tick=%b count=%0d busy=%b periods=%0d exp 0 0 0 1", tick, count, busy, periods); end
    do_start(1'b0, 4'd1, 4'd0);
    step();
    do_stop();
    checks++; if (tick !== 1'b0 || done !== 1'b0 || count !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL stp_oneshot got tick=%b done=%b count=%0d busy=%b exp 0 0 0 0", tick, done, count, busy); end
    checks++; if (periods !== 8'd0) begin failures++; $display("FAIL stp_os_periods got=%0d exp=0", periods); end
  endtask

  task automatic test_start_handling();
    start = 1'b1; stop = 1'b1; limit = 4'd5;
    step();
    start = 1'b0; stop = 1'b0;
    checks++; if (start_ack !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ss_idle got ack=%b busy=%b exp 0 0", start_ack, busy); end
    do_start(1'b1, 4'd2, 4'd0);
    step();
    start = 1'b1; limit = 4'd7; prescale = 4'd3; mode = 1'b0;
    step();
    start = 1'b0;
    checks++; if (start_ack !== 1'b0 || count !== 4'd2) begin failures++; $display("FAIL ss_busy_start got ack=%b count=%0d exp 0 2", start_ack, count); end
    step();
    checks++; if (count !== 4'd0 || tick !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL ss_orig_limit got count=%0d tick=%b done=%b busy=%b exp 0 1 0 1", count, tick, done, busy); end
    do_stop();
  endtask

  task automatic test_boundaries();
    int tcount;
    do_start(1'b1, 4'd0, 4'd0);
    tcount = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (tick === 1'b1 && count === 4'd0) tcount++;
    end
    checks++; if (tcount !== 3) begin failures++; $display("FAIL lim0_ticks got=%0d exp=3", tcount); end
    do_stop();
    do_start(1'b1, 4'd15, 4'd0);
    for (int i = 0; i < 15; i++) step();
    checks++; if (count !== 4'd15 || tick !== 1'b0) begin failures++; $display("FAIL full_e15 got count=%0d tick=%b exp 15 0", count, tick); end
    step();
    checks++; if (count !== 4'd0 || tick !== 1'b1) begin failures++; $display("FAIL full_wrap got count=%0d tick=%b exp 0 1", count, tick); end
    do_stop();
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_stop_terminal();
    test_start_handling();
    test_boundaries();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/counter_timer_ctrl.md
Name: counter_timer_ctrl

Overview:
Controller that sequences a free-running up-counter datapath into a programmable interval timer. It accepts a start/stop/pause command interface and latches limit, prescale and mode configuration on start. It drives the counter value and emits terminal-count ticks in one-shot or periodic mode. It sits between the software/config logic and downstream blocks that consume periodic events.

Parameters:
WIDTH, 4, counter/limit width in bits
PRESCALE_W, 4, prescale divider width in bits
PERIOD_W, 8, width of the saturating completed-period counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  request to begin timing; sampled only in IDLE
stop  in  1  abort; returns to IDLE from RUN or PAUSE
pause  in  1  level; freezes timing while high in RUN
mode  in  1  0 = one-shot, 1 = periodic; latched on accepted start
limit  in  WIDTH  terminal count value; latched on accepted start
prescale  in  PRESCALE_W  count advances every prescale+1 cycles; latched on accepted start
count  out  WIDTH  current counter value
busy  out  1  high in RUN or PAUSE
paused  out  1  high in PAUSE
start_ack  out  1  1-cycle pulse after start accepted
tick  out  1  1-cycle pulse when count wraps from limit to 0
done  out  1  1-cycle pulse at one-shot completion, coincident with tick
periods  out  PERIOD_W  number of ticks since last accepted start, saturating

Behaviour:
- Reset (async, any time including mid-run): state=IDLE; count=0, pre_cnt=0, periods=0; busy/paused/start_ack/tick/done=0; shadow limit/prescale/mode=0.
- All outputs are registered.
- States: IDLE, RUN, PAUSE.
- IDLE, start=1 and stop=0 at edge E0: latch limit_q/prescale_q/mode_q; count=0; pre_cnt=0; periods=0; start_ack=1 for the cycle after E0; go to RUN.
- IDLE, start and stop both high: stop wins, start is ignored, no start_ack.
- RUN, each edge with stop=0 and pause=0:
  - If pre_cnt==prescale_q: pre_cnt<=0 and take a step. Otherwise pre_cnt<=pre_cnt+1.
  - Step with count!=limit_q: count<=count+1.
  - Step with count==limit_q: count<=0, tick<=1, periods<=periods+1 (held at all-ones once there).
  - On that terminal step, if mode_q=0: done<=1 and go to IDLE.
- Latency example, prescale 0, limit 3: count after E1..E4 is 1,2,3,0; tick and done (one-shot) are high for the cycle after E4.
- limit_q=0: every step is terminal; count stays 0 and tick fires every prescale_q+1 cycles.
- RUN with pause=1 (stop=0): go to PAUSE; count and pre_cnt freeze; no tick.
- PAUSE: while pause=1, hold. When pause=0, return to RUN; counting resumes on the next edge from the frozen values.
- stop=1 in RUN or PAUSE: next state IDLE; count=0, pre_cnt=0; no tick/done, even on a would-be terminal step; periods retains its value.
- stop has priority over pause, and over terminal-step tick.
- start in RUN/PAUSE: ignored, no start_ack; configuration changes while busy have no effect.
- Counter arithmetic is modulo 2^WIDTH; limit=all-ones gives full-range wrap.
- start_ack, tick and done are never high for more than one consecutive cycle, except tick in periodic mode when limit_q=0 and prescale_q=0: tick is then high every cycle.

Test Plan:
- Reset mid-run (count=2): assert reset asynchronously between edges -> count=0, busy=0, tick=0 immediately; IDLE after release.
- One-shot, limit=3, prescale=0, start pulse -> start_ack 1 cycle; count 1,2,3,0; tick=done=1 one cycle; busy drops; periods=1.
- Periodic, limit=2, prescale=1 -> count advances every 2 cycles (0,0,1,1,2,2,0...); tick every 6 cycles; after 300 ticks periods=255 saturated.
- Pause at count=1 for 5 cycles -> count holds 1, paused=1, no tick; after release count continues 2,3...; tick timing shifted by exactly 5 cycles.
- Stop on the cycle count==limit with step due -> no tick, no done; count=0, IDLE; periods unchanged.
- start+stop together in IDLE -> no start_ack, stays IDLE. start pulse while RUN with new limit=7 -> ignored; original limit still governs wrap.
